// File: rtl/program_loader_if.sv
// Loader bus: host start/byte stream in, program-memory write port and CPU status out.
// The loader drives through 'master'; the host/memory/CPU side connects through 'slave'.
interface program_loader_if #(
    parameter int ADDR_W = 4
);
    logic              load_start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    modport master (
        input  load_start, in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
    );

    modport slave (
        output load_start, in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
    );
endinterface

// File: rtl/program_loader.sv
// Instruction-store writer: parses a COUNT/data/CHK byte frame, writes 16-bit words,
// NOP-fills the tail and releases the CPU only once the frame checksum is verified.
module program_loader #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    program_loader_if.master  bus
);
    typedef enum logic [2:0] {IDLE, COUNT, HI, LO, CHK, FILL, DONE, ERR} state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_t            state_q;
    logic [ADDR_W:0]   n_q, cnt_q;
    logic [7:0]        hi_q, sum_q;
    logic              in_ready_q, mem_we_q, cpu_hold_q, done_q, err_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [15:0]       mem_wdata_q;

    logic              accept;
    logic [7:0]        sum_d;
    logic [ADDR_W:0]   cnt_d;

    assign accept = bus.in_valid && in_ready_q;
    assign sum_d  = sum_q + bus.in_data;
    assign cnt_d  = cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            n_q         <= '0;
            cnt_q       <= '0;
            hi_q        <= '0;
            sum_q       <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            if (bus.load_start) begin
                // A low byte accepted this same cycle still lands in memory.
                if (state_q == LO && accept) begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= cnt_q[ADDR_W-1:0];
                    mem_wdata_q <= {hi_q, bus.in_data};
                end
                state_q    <= COUNT;
                in_ready_q <= 1'b1;
                err_q      <= 1'b0;
                sum_q      <= '0;
                cnt_q      <= '0;
                cpu_hold_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: ;
                    COUNT: if (accept) begin
                        sum_q <= sum_d;
                        if (bus.in_data == 8'd0 || bus.in_data > 8'(DEPTH)) begin
                            state_q    <= ERR;
                            in_ready_q <= 1'b0;
                            err_q      <= 1'b1;
                        end else begin
                            n_q     <= bus.in_data[ADDR_W:0];
                            cnt_q   <= '0;
                            state_q <= HI;
                        end
                    end
                    HI: if (accept) begin
                        sum_q   <= sum_d;
                        hi_q    <= bus.in_data;
                        state_q <= LO;
                    end
                    LO: if (accept) begin
                        sum_q       <= sum_d;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= cnt_q[ADDR_W-1:0];
                        mem_wdata_q <= {hi_q, bus.in_data};
                        cnt_q       <= cnt_d;
                        state_q     <= (cnt_d == n_q) ? CHK : HI;
                    end
                    CHK: if (accept) begin
                        sum_q      <= sum_d;
                        in_ready_q <= 1'b0;
                        if (sum_d != 8'd0) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end else if (n_q == DEPTH_C) begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= FILL;
                        end
                    end
                    // cnt_q enters at N; the cycle after the last NOP write raises done.
                    FILL: if (cnt_q == DEPTH_C) begin
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
                    end else begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= cnt_q[ADDR_W-1:0];
                        mem_wdata_q <= 16'h0000;
                        cnt_q       <= cnt_d;
                    end
                    DONE:    state_q <= IDLE;
                    ERR:     ;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_hold  = cpu_hold_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frames with hand-computed words/checksums,
// write log captured on the falling edge.
module tb_program_loader;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    program_loader_if #(.ADDR_W(ADDR_W)) bus();
    program_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0, n_fail = 0, cyc_n = 0, done_cnt = 0;

    typedef struct {int a; int d; int c;} wr_t;
    wr_t wr_q[$];

    always @(posedge clk) cyc_n++;
    always @(negedge clk) begin
        if (bus.mem_we) wr_q.push_back('{int'(bus.mem_addr), int'(bus.mem_wdata), cyc_n});
        if (bus.done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_q.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start();
        bus.load_start = 1'b1;
        cyc(1);
        bus.load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        bit ok = 1'b0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end
        end
        if (!ok) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && done_cnt == 0; i++) cyc(1);
    endtask

    logic [7:0]  f1   [10] = '{8'h04, 8'hA4, 8'h0F, 8'hB4, 8'h01, 8'hF4, 8'h00, 8'h81, 8'h00, 8'h1F};
    logic [15:0] exp1 [4]  = '{16'hA40F, 16'hB401, 16'hF400, 16'h8100};
    logic [7:0]  f2   [6]  = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hEA};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] m [DEPTH];
        bus.load_start = 1'b0;
        bus.in_data    = 8'h00;
        bus.in_valid   = 1'b0;
        cyc(3);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_mem_we",   bus.mem_we,   0);
        check("rst_addr",     bus.mem_addr, 0);
        check("rst_wdata",    bus.mem_wdata, 0);
        check("rst_hold",     bus.cpu_hold, 1);
        check("rst_done",     bus.done,     0);
        check("rst_err",      bus.err,      0);
        rst_n = 1'b1;
        cyc(2);
        check("idle_in_ready", bus.in_ready, 0);

        // 1: nominal 4-word load with fill
        clear_log();
        pulse_start();
        for (int i = 0; i < 9; i++) send(f1[i]);
        check("t1_hold_busy", bus.cpu_hold, 1);
        send(f1[9]);
        wait_done();
        cyc(3);
        check("t1_nwr", wr_q.size(), 16);
        if (wr_q.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                check($sformatf("t1_addr%0d", i), wr_q[i].a, i);
                check($sformatf("t1_data%0d", i), wr_q[i].d, (i < 4) ? 32'(exp1[i]) : 32'd0);
                if (i >= 5) check($sformatf("t1_fillgap%0d", i), wr_q[i].c - wr_q[i-1].c, 1);
            end
        end
        check("t1_done_cnt", done_cnt, 1);
        check("t1_hold", bus.cpu_hold, 0);
        check("t1_err", bus.err, 0);

        // 2: bad checksum
        clear_log();
        pulse_start();
        for (int i = 0; i < 9; i++) send(f1[i]);
        send(8'h20);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        cyc(5);
        check("t2_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        check("t2_nwr", wr_q.size(), 4);
        check("t2_err", bus.err, 1);
        check("t2_hold", bus.cpu_hold, 1);
        check("t2_done_cnt", done_cnt, 0);

        // 3: illegal counts
        clear_log();
        pulse_start();
        send(8'h11);
        check("t3_err_11", bus.err, 1);
        check("t3_rdy_11", bus.in_ready, 0);
        pulse_start();
        check("t3_err_clr", bus.err, 0);
        send(8'h00);
        check("t3_err_00", bus.err, 1);
        cyc(2);
        check("t3_rdy_00", bus.in_ready, 0);
        check("t3_nwr", wr_q.size(), 0);

        // 4: full 16-word program, back-to-back; CHK=00 by hand
        clear_log();
        pulse_start();
        send(8'h10);
        for (int i = 0; i < 16; i++) begin
            send(8'h20 + 8'(i));
            send(8'h80 + 8'(i));
        end
        send(8'h00);
        check("t4_done", bus.done, 1);
        check("t4_hold", bus.cpu_hold, 0);
        cyc(3);
        check("t4_nwr", wr_q.size(), 16);
        if (wr_q.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                check($sformatf("t4_addr%0d", i), wr_q[i].a, i);
                check($sformatf("t4_data%0d", i), wr_q[i].d, {16'd0, 8'h20 + 8'(i), 8'h80 + 8'(i)});
                if (i >= 1) check($sformatf("t4_gap%0d", i), wr_q[i].c - wr_q[i-1].c, 2);
            end
        end
        check("t4_done_cnt", done_cnt, 1);

        // 5: abort mid-frame, then gapped N=2 frame
        clear_log();
        pulse_start();
        send(8'h02);
        send(8'h11);
        send(8'h22);
        pulse_start();
        clear_log();
        for (int i = 0; i < 6; i++) begin
            send(f2[i]);
            cyc($urandom_range(0, 3));
        end
        wait_done();
        cyc(3);
        for (int i = 0; i < DEPTH; i++) m[i] = 16'hFFFF;
        foreach (wr_q[k]) m[wr_q[k].a] = 16'(wr_q[k].d);
        check("t5_nwr", wr_q.size(), 16);
        check("t5_m0", m[0], 16'h1234);
        check("t5_m1", m[1], 16'h5678);
        for (int i = 2; i < DEPTH; i++) check($sformatf("t5_m%0d", i), m[i], 16'h0000);
        check("t5_done_cnt", done_cnt, 1);
        check("t5_err", bus.err, 0);

        // 6: async reset during fill
        clear_log();
        pulse_start();
        for (int i = 0; i < 6; i++) send(f2[i]);
        cyc(2);
        check("t6_in_fill", bus.mem_we, 1);
        #3 rst_n = 1'b0;
        #1;
        check("t6_mem_we", bus.mem_we, 0);
        check("t6_hold", bus.cpu_hold, 1);
        check("t6_in_ready", bus.in_ready, 0);
        check("t6_done", bus.done, 0);
        check("t6_err", bus.err, 0);
        #2 rst_n = 1'b1;
        cyc(1);
        clear_log();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h02;
        cyc(5);
        check("t6_idle_rdy", bus.in_ready, 0);
        check("t6_idle_nwr", wr_q.size(), 0);
        check("t6_idle_hold", bus.cpu_hold, 1);
        check("t6_idle_done", done_cnt, 0);
        bus.in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Writer side of the CPU instruction store. It receives a framed byte stream (valid/ready) and assembles 16-bit instructions high byte first. It writes them into the writable program memory that the CPU fetches from through its combinational read port, and zero-fills (NOP) the unused tail. It holds the CPU in stall until a complete, checksum-verified program is resident.

Parameters:
ADDR_W, 4, program memory address width.
DEPTH, 16, number of instruction words; must equal 2**ADDR_W.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
load_start  input  1  single-cycle pulse; begins or restarts a load.
in_data  input  8  stream byte.
in_valid  input  1  in_data valid.
in_ready  output  1  loader accepts a byte this cycle.
mem_we  output  1  program memory write strobe, one cycle per word.
mem_addr  output  ADDR_W  write address.
mem_wdata  output  16  instruction word.
cpu_hold  output  1  CPU stall; high while no valid program is loaded.
done  output  1  one-cycle pulse on successful load.
err  output  1  sticky load error; cleared by load_start.

Behaviour:
- Reset is asynchronous and active-low. It applies on the cycle rst_n falls and is released synchronously to clk. Reset values: state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, err=0, checksum=0.
- A byte is accepted on a rising edge with in_valid && in_ready. All outputs are registered.
- Frame format:
  - COUNT byte N, legal range 1..DEPTH.
  - 2N data bytes, high byte then low byte per word.
  - CHK byte, chosen so that the 8-bit sum of all frame bytes (COUNT + data + CHK) = 0x00 mod 256.
- States:
  - IDLE: in_ready=0. Wait for load_start.
  - COUNT: in_ready=1. Byte 0 or >DEPTH -> ERR. Otherwise latch N, word counter=0 -> HI.
  - HI: in_ready=1. Latch high byte -> LO.
  - LO: in_ready=1. On accept, on the next edge drive mem_we=1, mem_addr=word counter, mem_wdata={hi,byte}, then increment the counter. If counter reaches N -> CHK, else -> HI. Back-to-back bytes are accepted with no bubbles.
  - CHK: in_ready=1. Accept the byte. Sum==0 -> FILL if N<DEPTH, else DONE. Sum!=0 -> ERR.
  - FILL: in_ready=0. One write per cycle, mem_wdata=0x0000, addresses N..DEPTH-1 -> DONE.
  - DONE: done=1 for exactly one cycle. cpu_hold falls on the same edge. -> IDLE.
  - ERR: err=1, in_ready=0, no writes, cpu_hold stays 1. Exit only via load_start.
- Running checksum: 8-bit wrap-around accumulate of every accepted byte, including COUNT and CHK. Cleared on load_start.
- load_start in any state:
  - Next state is COUNT.
  - Clears err, checksum and word counter.
  - Sets cpu_hold=1.
  - Any in-flight mem_we from a LO accept in the same cycle still completes.
- Address counter never wraps: the last write address is DEPTH-1, and FILL is skipped when N=DEPTH.
- Bytes presented while in_ready=0 are ignored and not consumed.
- mem_we is never high in IDLE, COUNT, CHK, ERR or DONE except for the single LO-completion write that follows a LO accept.

Test Plan:
1. Nominal load:
   - Stimulus: load_start, then 04 A4 0F B4 01 F4 00 81 00 1F.
   - Required: writes addr0=A40F, addr1=B401, addr2=F400, addr3=8100, then addr4..15=0000 on consecutive cycles. Then a single done pulse, cpu_hold 1->0, err=0.
2. Bad checksum:
   - Stimulus: same frame with CHK=20.
   - Required: 4 data writes only, no fill writes, err=1, cpu_hold=1, done never asserts, in_ready=0 until the next load_start.
3. Illegal count:
   - Stimulus: COUNT=11 (hex), then COUNT=00 after a new load_start.
   - Required: err=1 the cycle after each, zero writes, in_ready=0.
4. Full program:
   - Stimulus: N=16 (0x10), 32 back-to-back data bytes, valid CHK.
   - Required: 16 writes addr0..15, no fill, done the cycle after the CHK accept state transition.
5. Abort and gaps:
   - Stimulus: load_start, then 3 bytes, then load_start again. Then a valid N=2 frame with random in_valid gaps.
   - Required: no corruption; writes addr0..1 with the new words, addr2..15 filled with 0000, done, err=0.
6. Async reset mid-FILL:
   - Stimulus: rst_n low between clock edges.
   - Required: mem_we=0, cpu_hold=1, in_ready=0, done=0, err=0 immediately. After release, loader idles until load_start.
